// File: rtl/iob_pcie_rx_chnl_pkg.sv
// Shared constants for the PCIe receive-channel engine:
// FSM state encodings and default sizing.
package iob_pcie_rx_chnl_pkg;

  localparam int DEFAULT_DATA_W  = 32;
  localparam int DEFAULT_FIFO_AW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/iob_pcie_rx_chnl_if.sv
// Bundle of the CHNL_RX handshake, the CPU drain port and the status
// outputs. The engine uses the slave view; the PCIe core/CPU side
// uses the master view.
interface iob_pcie_rx_chnl_if
  import iob_pcie_rx_chnl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int FIFO_AW = DEFAULT_FIFO_AW
);

  logic              chnl_rx;
  logic              chnl_rx_ack;
  logic              chnl_rx_last;
  logic [31:0]       chnl_rx_len;
  logic [30:0]       chnl_rx_off;
  logic [DATA_W-1:0] chnl_rx_data;
  logic              chnl_rx_data_valid;
  logic              chnl_rx_data_ren;

  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready;

  logic              busy;
  logic              done;
  logic              truncated;
  logic              last_q;
  logic [30:0]       off_q;
  logic [31:0]       words_rcvd;
  logic [FIFO_AW:0]  level;

  modport slave (
    input  chnl_rx, chnl_rx_last, chnl_rx_len, chnl_rx_off,
           chnl_rx_data, chnl_rx_data_valid, rd_ready,
    output chnl_rx_ack, chnl_rx_data_ren, rd_valid, rd_data,
           busy, done, truncated, last_q, off_q, words_rcvd, level
  );

  modport master (
    output chnl_rx, chnl_rx_last, chnl_rx_len, chnl_rx_off,
           chnl_rx_data, chnl_rx_data_valid, rd_ready,
    input  chnl_rx_ack, chnl_rx_data_ren, rd_valid, rd_data,
           busy, done, truncated, last_q, off_q, words_rcvd, level
  );

endinterface

// File: rtl/iob_pcie_rx_chnl_fifo.sv
// Synchronous first-word fall-through FIFO. Pushes are dropped when
// full and pops are ignored when empty, so callers may present raw
// requests.
module iob_pcie_rx_chnl_fifo
  import iob_pcie_rx_chnl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [FIFO_AW:0]  o_level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // The count only reaches DEPTH when full, so its MSB is the full flag.
  assign o_full  = r_count[FIFO_AW];
  assign o_empty = (r_count == '0);
  assign o_level = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally at 2^FIFO_AW; the count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/iob_pcie_rx_chnl.sv
// Receive-channel engine: acknowledges a CHNL_RX transaction, accepts
// its words under FIFO flow control and buffers them for the CPU.
module iob_pcie_rx_chnl
  import iob_pcie_rx_chnl_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int FIFO_AW = DEFAULT_FIFO_AW
) (
  input logic                 clk,
  input logic                 rst,
  iob_pcie_rx_chnl_if.slave   bus
);

  logic [1:0]        r_state;
  logic [31:0]       r_len;
  logic [31:0]       r_words;
  logic [30:0]       r_off;
  logic              r_last;
  logic              r_trunc;

  logic              w_full;
  logic              w_empty;
  logic              w_ren;
  logic              w_accept;
  logic              w_final;
  logic [FIFO_AW:0]  w_level;
  logic [DATA_W-1:0] w_rdData;

  // Read-enable depends only on registered state and FIFO flags.
  assign w_ren    = (r_state == ST_RECV) && !w_full && (r_words != r_len);
  assign w_accept = w_ren && bus.chnl_rx_data_valid;
  assign w_final  = w_accept && ((r_words + 32'd1) == r_len);

  assign bus.chnl_rx_ack      = (r_state == ST_ACK);
  assign bus.chnl_rx_data_ren = w_ren;
  assign bus.busy             = (r_state != ST_IDLE);
  assign bus.done             = (r_state == ST_DONE);
  assign bus.truncated        = r_trunc;
  assign bus.last_q           = r_last;
  assign bus.off_q            = r_off;
  assign bus.words_rcvd       = r_words;
  assign bus.level            = w_level;
  assign bus.rd_valid         = !w_empty;
  assign bus.rd_data          = w_rdData;

  // Transaction FSM with request capture and the accepted-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_words <= '0;
      r_off   <= '0;
      r_last  <= 1'b0;
      r_trunc <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.chnl_rx) begin
            r_len   <= bus.chnl_rx_len;
            r_last  <= bus.chnl_rx_last;
            r_off   <= bus.chnl_rx_off;
            r_words <= '0;
            r_trunc <= 1'b0;
            r_state <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_state <= (r_len == 32'd0) ? ST_DONE : ST_RECV;
        end
        ST_RECV: begin
          if (w_accept) r_words <= r_words + 32'd1;
          if (w_final || (r_words == r_len)) begin
            r_state <= ST_DONE;
          end else if (!bus.chnl_rx) begin
            r_state <= ST_DONE;
            r_trunc <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  iob_pcie_rx_chnl_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_accept),
    .i_wdata (bus.chnl_rx_data),
    .i_pop   (bus.rd_ready),
    .o_rdata (w_rdData),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

endmodule

// File: tb/tb_iob_pcie_rx_chnl.sv
// Directed testbench for the receive-channel engine: a per-cycle vector
// table for the basic transaction plus hand-written multi-cycle sequences.
module tb_iob_pcie_rx_chnl;

  logic clk;
  logic rst;

  int checkCount;
  int passCount;

  typedef struct {
    logic        rx;
    logic        valid;
    logic [31:0] data;
    logic        rdReady;
    logic        ack;
    logic        ren;
    logic        done;
    logic        busy;
    logic        rdValid;
    logic [31:0] rdData;
  } vec_t;

  vec_t vecs[8];

  iob_pcie_rx_chnl_if #(.DATA_W(32), .FIFO_AW(4)) bus ();

  iob_pcie_rx_chnl #(.DATA_W(32), .FIFO_AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.chnl_rx            = v.rx;
    bus.chnl_rx_data_valid = v.valid;
    bus.chnl_rx_data       = v.data;
    bus.rd_ready           = v.rdReady;
  endtask

  // Drives one transaction and drains the FIFO, scoreboarding every word.
  task automatic runXfer(input string tag, input int len, input logic [31:0] base,
                         input int dropAfter, input int rdyHold,
                         input bit irregular, input bit checkFull);
    int acc, rd, maxLvl, expCount;
    bit reqActive, doneSeen, finished, expTrunc;
    logic [0:6] pat;
    pat       = 7'b1001101;
    acc       = 0;
    rd        = 0;
    maxLvl    = 0;
    reqActive = 1'b1;
    doneSeen  = 1'b0;
    finished  = 1'b0;
    expTrunc  = (dropAfter >= 0) && (dropAfter < len);
    expCount  = expTrunc ? dropAfter : len;
    bus.chnl_rx_len  = len;
    bus.chnl_rx_last = 1'b0;
    bus.chnl_rx_off  = 31'h5;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (doneSeen && !bus.busy && !bus.rd_valid) begin
        finished = 1'b1;
      end else begin
        if (bus.done) begin
          doneSeen  = 1'b1;
          reqActive = 1'b0;
        end
        if (reqActive && dropAfter >= 0 && acc == dropAfter) reqActive = 1'b0;
        bus.chnl_rx = reqActive;
        if (!reqActive || cyc < 2) bus.chnl_rx_data_valid = 1'b0;
        else bus.chnl_rx_data_valid = irregular ? pat[(cyc - 2) % 7] : 1'b1;
        bus.chnl_rx_data = base + acc;
        if (rdyHold < 0) bus.rd_ready = 1'($urandom_range(0, 1));
        else bus.rd_ready = (cyc >= rdyHold);
        #1;
        if (checkFull && cyc == rdyHold - 1) begin
          checkOutput({tag, "_full_level"}, bus.level, 16);
          checkOutput({tag, "_full_ren"}, bus.chnl_rx_data_ren, 0);
          checkOutput({tag, "_full_accepted"}, acc, 16);
        end
        if (bus.chnl_rx_data_valid && bus.chnl_rx_data_ren) acc++;
        if (bus.rd_valid && bus.rd_ready) begin
          checkOutput({tag, "_word"}, bus.rd_data, base + rd);
          rd++;
        end
        if (int'(bus.level) > maxLvl) maxLvl = int'(bus.level);
      end
    end
    checkOutput({tag, "_finished"}, finished, 1);
    checkOutput({tag, "_done_seen"}, doneSeen, 1);
    checkOutput({tag, "_words_read"}, rd, expCount);
    checkOutput({tag, "_words_rcvd"}, bus.words_rcvd, expCount);
    checkOutput({tag, "_truncated"}, bus.truncated, expTrunc);
    checkOutput({tag, "_max_level_ok"}, maxLvl <= 16, 1);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    bus.chnl_rx = 1'b0;
    bus.chnl_rx_last = 1'b0;
    bus.chnl_rx_len = '0;
    bus.chnl_rx_off = '0;
    bus.chnl_rx_data = '0;
    bus.chnl_rx_data_valid = 1'b0;
    bus.rd_ready = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", bus.chnl_rx_ack, 0);
    checkOutput("rst_ren", bus.chnl_rx_data_ren, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_trunc", bus.truncated, 0);
    checkOutput("rst_last", bus.last_q, 0);
    checkOutput("rst_off", bus.off_q, 0);
    checkOutput("rst_words", bus.words_rcvd, 0);
    checkOutput("rst_level", bus.level, 0);
    checkOutput("rst_rd_valid", bus.rd_valid, 0);
    rst = 1'b0;

    // Basic len=4 transaction, one row per cycle starting at the request.
    vecs[0] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0};
    vecs[4] = '{1'b1, 1'b1, 32'hA2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA1};
    vecs[5] = '{1'b1, 1'b1, 32'hA3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA2};
    vecs[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3};
    vecs[7] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    bus.chnl_rx_len  = 32'd4;
    bus.chnl_rx_last = 1'b1;
    bus.chnl_rx_off  = 31'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d_ack", i), bus.chnl_rx_ack, vecs[i].ack);
      checkOutput($sformatf("vec%0d_ren", i), bus.chnl_rx_data_ren, vecs[i].ren);
      checkOutput($sformatf("vec%0d_done", i), bus.done, vecs[i].done);
      checkOutput($sformatf("vec%0d_busy", i), bus.busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d_rd_valid", i), bus.rd_valid, vecs[i].rdValid);
      if (vecs[i].rdValid)
        checkOutput($sformatf("vec%0d_rd_data", i), bus.rd_data, vecs[i].rdData);
    end
    checkOutput("basic_words", bus.words_rcvd, 4);
    checkOutput("basic_last", bus.last_q, 1);
    checkOutput("basic_off", bus.off_q, 31'h10);
    checkOutput("basic_trunc", bus.truncated, 0);

    // Zero-length transaction: ack then done two cycles after the request.
    @(negedge clk);
    bus.chnl_rx = 1'b1;
    bus.chnl_rx_len = 32'd0;
    bus.chnl_rx_last = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("len0_ack", bus.chnl_rx_ack, 1);
    checkOutput("len0_ren_ack", bus.chnl_rx_data_ren, 0);
    @(negedge clk);
    bus.chnl_rx = 1'b0;
    #1;
    checkOutput("len0_done", bus.done, 1);
    checkOutput("len0_ren_done", bus.chnl_rx_data_ren, 0);
    checkOutput("len0_words", bus.words_rcvd, 0);
    @(negedge clk);
    #1;
    checkOutput("len0_idle", bus.busy, 0);

    // FIFO back-pressure, truncation and irregular-valid transfers.
    runXfer("full", 20, 32'hB00, -1, 25, 1'b0, 1'b1);
    runXfer("trunc", 8, 32'hC00, 5, 0, 1'b0, 1'b0);
    runXfer("irreg", 4, 32'hE00, -1, -1, 1'b1, 1'b0);

    // Reset in the middle of a transaction after three accepted words.
    @(negedge clk);
    bus.chnl_rx = 1'b1;
    bus.chnl_rx_len = 32'd8;
    bus.chnl_rx_data_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.chnl_rx_data = 32'hF0 + i;
      bus.chnl_rx_data_valid = 1'b1;
    end
    @(negedge clk);
    bus.chnl_rx_data_valid = 1'b0;
    #1;
    checkOutput("midrst_level_before", bus.level, 3);
    rst = 1'b1;
    #1;
    checkOutput("midrst_busy", bus.busy, 0);
    checkOutput("midrst_level", bus.level, 0);
    checkOutput("midrst_rd_valid", bus.rd_valid, 0);
    checkOutput("midrst_ren", bus.chnl_rx_data_ren, 0);
    checkOutput("midrst_words", bus.words_rcvd, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.chnl_rx = 1'b0;
    runXfer("recover", 2, 32'hD00, -1, 0, 1'b0, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/iob_pcie_rx_chnl.md
# iob_pcie_rx_chnl

Receive-channel engine for the PCIe peripheral. It terminates the RIFFA-style CHNL_RX handshake: it acknowledges an incoming transaction, accepts its data words under flow control, and buffers them in a small FIFO. The CPU-side register logic drains that FIFO one word at a time. The block sits between the PCIe core's RX channel pins and the iob_pcie software-register read path.

## Interface
Parameters:
- DATA_W, 32, data word width.
- FIFO_AW, 4, log2 of the FIFO depth (default depth 16).

Ports:
- clk  in  1  system clock; the channel is synchronous to it.
- rst  in  1  reset, asynchronous and active-high.
- chnl_rx  in  1  transaction request; held high for the whole transaction.
- chnl_rx_ack  out  1  one-cycle acknowledge of the request.
- chnl_rx_last  in  1  marks the final transaction of a transfer; captured with the request.
- chnl_rx_len  in  32  transaction length in DATA_W words; captured with the request.
- chnl_rx_off  in  31  word offset; captured with the request.
- chnl_rx_data  in  DATA_W  incoming word.
- chnl_rx_data_valid  in  1  the incoming word is valid.
- chnl_rx_data_ren  out  1  the block accepts the word this cycle.
- rd_valid  out  1  FIFO is not empty.
- rd_data  out  DATA_W  FIFO head word (first-word fall-through).
- rd_ready  in  1  pops the head word when rd_valid is high.
- busy  out  1  a transaction is in progress (state is not IDLE).
- done  out  1  one-cycle pulse at the end of a transaction.
- truncated  out  1  the last transaction ended before its length was reached; sticky until the next request.
- last_q  out  1  captured chnl_rx_last.
- off_q  out  31  captured chnl_rx_off.
- words_rcvd  out  32  number of words accepted in the current or last transaction.
- level  out  FIFO_AW+1  FIFO occupancy.

## Operation
- FSM states: IDLE, ACK, RECV, DONE.
- IDLE:
  - When chnl_rx is high, capture len_q, last_q and off_q.
  - Clear words_rcvd and truncated.
  - Go to ACK.
- ACK:
  - chnl_rx_ack is high for exactly this cycle.
  - Go to DONE if len_q is 0, otherwise go to RECV.
- RECV:
  - chnl_rx_data_ren = !full && (words_rcvd != len_q). This is combinational from registered state and the FIFO flags.
  - A word is accepted when chnl_rx_data_valid and chnl_rx_data_ren are both high. On accept, push the word into the FIFO and increment words_rcvd (32-bit, no wrap needed because it is bounded by len_q).
  - Go to DONE when words_rcvd == len_q, or one cycle after the final accept that makes them equal.
  - Go to DONE when chnl_rx is sampled low while words_rcvd < len_q; set truncated.
- DONE:
  - done is high for this cycle.
  - Go to IDLE.
  - A new request is not sampled until IDLE, so back-to-back transactions are separated by at least one idle cycle.
- FIFO:
  - Synchronous, first-word fall-through.
  - Full: no push. chnl_rx_data_ren is low even if a pop happens in the same cycle.
  - Empty: rd_valid is low, and rd_ready is ignored.
  - Simultaneous push and pop when neither full nor empty: level is unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- Reset outputs (asynchronous):
  - State is IDLE.
  - chnl_rx_ack, chnl_rx_data_ren, busy, done, truncated, last_q = 0.
  - off_q, words_rcvd, level = 0.
  - rd_valid = 0.
  - FIFO pointers are cleared; FIFO contents are don't-care.
- Reset mid-transaction: the block drops to IDLE immediately and the buffered data is discarded. Recovery of the channel is the host's job.

## Timing
- chnl_rx high at cycle N → state is ACK at N+1 with chnl_rx_ack high → RECV at N+2, the first cycle in which chnl_rx_data_ren can be high.
- Accept-to-rd_valid latency: 1 cycle. A word accepted at cycle M is visible on rd_data at M+1 when the FIFO was empty.
- Pop: rd_data updates in the cycle after rd_valid && rd_ready.
- Sustained throughput: 1 word/cycle while the FIFO is not full.
- done rises the cycle after the final accept, then busy falls on the next cycle.

## Structure
- Header iob_pcie_rx_defs.vh holds:
  - State encodings (2-bit: IDLE=0, ACK=1, RECV=2, DONE=3).
  - Default FIFO_AW.
- Sub-module iob_pcie_rx_fifo: parameterised synchronous FWFT FIFO (DATA_W, FIFO_AW) with full, empty and level outputs.
- Top level: FSM, capture registers and counter.
- All registers are reset asynchronously by rst.

## Test plan
- Reset mid-RECV after 3 words → immediate IDLE; level=0; rd_valid=0; chnl_rx_data_ren=0; next request (len=2) completes normally.
- Request len=4, last=1, off=0x10; data 0xA0..0xA3 valid every cycle; rd_ready=1 → ack is one cycle at N+1; ren is high at N+2..N+5; done at N+6; words_rcvd=4; CPU reads A0,A1,A2,A3 in order; last_q=1; off_q=0x10.
- len=20 with FIFO_AW=4 and rd_ready=0 → ren drops after 16 accepts and level=16; set rd_ready=1 → remaining 4 accepted; done asserted; total 20 words read in order.
- len=0 → ack, then done two cycles after the request; no ren pulse; words_rcvd=0.
- len=8; chnl_rx dropped after 5 words → DONE with truncated=1; words_rcvd=5; 5 words readable.
- Irregular chnl_rx_data_valid (1,0,0,1,1,0,1) and random rd_ready, len=4 → no dropped or duplicated words; level never exceeds 16.
